// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mul_pkg;

    localparam int unsigned MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_e;

    // Counter must hold 0..w inclusive.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/add_w.sv
// WIDTH-bit ripple-carry adder, a chain of full-adder cells. Purely combinational.
module add_w #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential unsigned shift-add multiplier, one partial product per clock on a shared adder.
// Optional early exit when the remaining multiplier bits are zero: define EARLY_TERM_EN.
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    mul_state_e         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mcnd;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] r_prod;

    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH:0]     w_hi;
    logic [2*WIDTH-1:0] w_p_step;
    logic [2*WIDTH-1:0] w_p_nxt;
    logic               w_finish;
`ifdef EARLY_TERM_EN
    logic               w_early;
`endif

    add_w #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (r_p[2*WIDTH-1:WIDTH]),
        .b    (r_mcnd),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Carry-out is kept as the top bit of the shifted 2W+1-bit value.
    always_comb begin
        w_hi     = r_p[0] ? {w_cout, w_sum} : {1'b0, r_p[2*WIDTH-1:WIDTH]};
        w_p_step = {w_hi, r_p[WIDTH-1:1]};
`ifdef EARLY_TERM_EN
        w_early  = ((r_p[WIDTH-1:0] & ({WIDTH{1'b1}} >> r_cnt)) == '0);
        w_p_nxt  = w_early ? (r_p >> (WIDTH - 32'(r_cnt))) : w_p_step;
        w_finish = w_early || (r_cnt == CNT_W'(WIDTH - 1));
`else
        w_p_nxt  = w_p_step;
        w_finish = (r_cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_finish) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mcnd  <= '0;
            r_p     <= '0;
            r_prod  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcnd <= dataA;
                        r_p    <= {{WIDTH{1'b0}}, dataB};
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_p   <= w_p_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_finish) begin
                        r_prod <= w_p_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_prod;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed cases plus 1000 random back-to-back operations.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clocks from driving start to seeing done (start drive cycle counts as 0).
    function automatic int exp_lat(input logic [31:0] b);
`ifdef EARLY_TERM_EN
        int msb;
        int runs;
        msb = -1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) msb = i;
        end
        if (msb < 0) return 2;
        runs = (msb + 2 < 32) ? msb + 2 : 32;
        return runs + 1;
`else
        return 33;
`endif
    endfunction

    // Drives one operation; hold keeps start high for back-to-back use,
    // poke pulses start (with new operands) at that cycle of the op.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                         input int poke);
        int          lat;
        int          first;
        int          dones;
        int          busy_n;
        logic [63:0] got;
        logic [63:0] exp_p;
        lat    = exp_lat(b);
        exp_p  = {32'b0, a} * {32'b0, b};
        first  = 0;
        dones  = 0;
        busy_n = 0;
        got    = '0;
        dataA  = a;
        dataB  = b;
        start  = 1'b1;
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            if (!hold) start = (n == poke);
            if (n == poke) begin
                dataA = $urandom;
                dataB = $urandom;
            end
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = n;
                    got   = product;
                end
            end
            if (hold && dones != 0) break;
        end
        check("latency", 64'(first), 64'(lat));
        check("product", got, exp_p);
        check("busy_cycles", 64'(busy_n), 64'(lat));
        check("done_pulses", 64'(dones), 64'd1);
        if (hold) begin
            @(negedge clk);
            check("idle_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          dones;
        reset = 1'b1;
        start = 1'b0;
        dataA = '0;
        dataB = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(32'd3, 32'd5, 1'b0, -1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        do_op(32'd7, 32'd9, 1'b0, 5);

        // Reset in the middle of a run discards the result.
        dataA = 32'd11;
        dataB = 32'hFFFF_0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_done", 64'(done), 64'd0);
        check("midrun_reset_product", product, 64'd0);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_reset", 64'(dones), 64'd0);
        do_op(32'd123456, 32'd654321, 1'b0, -1);

        do_op(32'hDEAD_BEEF, 32'd0, 1'b0, -1);
        do_op(32'h1234_5678, 32'd1, 1'b0, -1);
        do_op(32'h8000_0001, 32'h8000_0000, 1'b0, -1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = 32'($urandom >> $urandom_range(0, 32));
            do_op(ra, rb, 1'b1, -1);
        end
        start = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
